// File: rtl/component_regs_pkg.sv
// Register package for the component control/status bank.
// Holds the register map layout, the derived mask/reset constants a parent
// uses to parametrise component_register_bank, and the bank FSM state type.
// Optional feature macro: COMPONENT_REGS_W1C_EN (sticky write-1-to-clear bits).
package component_regs_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_NUM_WORDS  = 4;

  typedef struct packed {
    logic [7:0]  major;
    logic [7:0]  minor;
    logic [15:0] build;
  } version_register_t;

  // First member is the most significant word, so word 0 is the version.
  typedef struct packed {
    logic [31:0]       status;  // word 3
    logic [31:0]       irq;     // word 2
    logic [31:0]       ctrl;    // word 1
    version_register_t version; // word 0
  } component_registers_t;

  typedef logic [$bits(component_registers_t)-1:0] register_bits_t;

  localparam register_bits_t COMPONENT_READ_MASK =
    register_bits_t'(component_registers_t'{default: '1});

  // The version word is a constant field: never host-writable.
  localparam register_bits_t COMPONENT_WRITE_MASK =
    register_bits_t'(component_registers_t'{version: '0, default: '1});

  localparam register_bits_t COMPONENT_RESET_VALUE =
    register_bits_t'(component_registers_t'{
      version: '{major: 8'd1, minor: 8'd0, build: 16'd3},
      default: '0});

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bank_state_t;

endpackage

// File: rtl/component_reg_word.sv
// One DATA_WIDTH register of the bank with its own mask and reset slices.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   wr_en_i        host write strobe (already address-decoded)
//   wdata_i        host write data
//   hw_set_i       sticky-status set pulses (only with COMPONENT_REGS_W1C_EN)
//   value_o        unmasked register contents
//   rdata_o        register contents with the read mask applied
// With COMPONENT_REGS_W1C_EN defined, bits that are both readable and
// writable are sticky write-1-to-clear and hw_set wins over a clear.
module component_reg_word
  import component_regs_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] READ_MASK   = '1,
  parameter logic [DATA_WIDTH-1:0] WRITE_MASK  = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
)(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
`ifdef COMPONENT_REGS_W1C_EN
  input  logic [DATA_WIDTH-1:0] hw_set_i,
`endif
  output logic [DATA_WIDTH-1:0] value_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] value_q, value_d;

`ifdef COMPONENT_REGS_W1C_EN
  localparam logic [DATA_WIDTH-1:0] W1C_MASK   = WRITE_MASK & READ_MASK;
  localparam logic [DATA_WIDTH-1:0] PLAIN_MASK = WRITE_MASK & ~READ_MASK;
  // Write-only plain bits are not status bits, so hardware cannot set them.
  localparam logic [DATA_WIDTH-1:0] SET_MASK   = ~PLAIN_MASK;

  always_comb begin
    value_d = value_q;
    if (wr_en_i) begin
      value_d = (value_q & ~WRITE_MASK)
              | (wdata_i & PLAIN_MASK)
              | (value_q & W1C_MASK & ~wdata_i);
    end
    // Applied after the clear so a same-cycle set wins.
    value_d = value_d | (hw_set_i & SET_MASK);
  end
`else
  always_comb begin
    value_d = value_q;
    if (wr_en_i) begin
      value_d = (value_q & ~WRITE_MASK) | (wdata_i & WRITE_MASK);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) value_q <= RESET_VALUE;
    else         value_q <= value_d;
  end

  assign value_o = value_q;
  assign rdata_o = value_q & READ_MASK;

endmodule

// File: rtl/component_register_bank.sv
// Bus-accessible bank of NUM_WORDS control/status registers.
// Single-outstanding request/response handshake; one access per two cycles.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_write, req_addr, req_wdata request fields (word address)
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_error          masked read data, out-of-range flag
//   regs_out                      flattened unmasked register contents
//   hw_set                        sticky-status set pulses (COMPONENT_REGS_W1C_EN only)
//
// state | meaning
// IDLE  | ready for a request; an accepted request is performed on that edge
// RESP  | response held stable until rsp_ready; new requests ignored
module component_register_bank
  import component_regs_pkg::*;
#(
  parameter int                                NUM_WORDS   = 4,
  parameter int                                DATA_WIDTH  = 32,
  parameter logic [NUM_WORDS*DATA_WIDTH-1:0]   READ_MASK   = '1,
  parameter logic [NUM_WORDS*DATA_WIDTH-1:0]   WRITE_MASK  = '0,
  parameter logic [NUM_WORDS*DATA_WIDTH-1:0]   RESET_VALUE = '0,
  localparam int                               ADDR_WIDTH  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
)(
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [DATA_WIDTH-1:0]           req_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_error,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] regs_out
`ifdef COMPONENT_REGS_W1C_EN
  ,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] hw_set
`endif
);

  bank_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  logic                  accept;
  logic                  addr_ok;
  logic [NUM_WORDS-1:0]  wr_en;
  logic [DATA_WIDTH-1:0] word_rdata [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rd_word;

  assign accept = (state_q == IDLE) && req_valid;

  // Out-of-range addresses only exist when NUM_WORDS is not a power of two.
  if (NUM_WORDS == (1 << ADDR_WIDTH)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_partial
    assign addr_ok = (req_addr < ADDR_WIDTH'(NUM_WORDS));
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    assign wr_en[k] = accept && req_write && addr_ok && (req_addr == ADDR_WIDTH'(k));

    component_reg_word #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_MASK   (READ_MASK  [k*DATA_WIDTH +: DATA_WIDTH]),
      .WRITE_MASK  (WRITE_MASK [k*DATA_WIDTH +: DATA_WIDTH]),
      .RESET_VALUE (RESET_VALUE[k*DATA_WIDTH +: DATA_WIDTH])
    ) u_word (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .wr_en_i  (wr_en[k]),
      .wdata_i  (req_wdata),
`ifdef COMPONENT_REGS_W1C_EN
      .hw_set_i (hw_set[k*DATA_WIDTH +: DATA_WIDTH]),
`endif
      .value_o  (regs_out[k*DATA_WIDTH +: DATA_WIDTH]),
      .rdata_o  (word_rdata[k])
    );
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (req_addr == ADDR_WIDTH'(k)) rd_word = word_rdata[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = RESP;
          rsp_error_d = !addr_ok;
          rsp_rdata_d = (!req_write && addr_ok) ? rd_word : '0;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_component_register_bank.sv
// Directed bench for component_register_bank with a 3-word, 32-bit map.
// Word 0: constant 32'h1234_5678. Word 1: lower half writable.
// Word 2: bits 0-3 readable+writable, bits 4-7 write-only.
module tb_component_register_bank;

  localparam int NW = 3;
  localparam int DW = 32;

  localparam logic [NW*DW-1:0] RM = {32'h0000_000F, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [NW*DW-1:0] WM = {32'h0000_00FF, 32'h0000_FFFF, 32'h0000_0000};
  localparam logic [NW*DW-1:0] RV = {32'h0000_0000, 32'h0000_0000, 32'h1234_5678};

`ifdef COMPONENT_REGS_W1C_EN
  // Readable+writable bits are sticky W1C, so host writes of 1 only clear.
  localparam logic [31:0] EXP_W1    = 32'h0000_0000;
  localparam logic [31:0] EXP_W2REG = 32'h0000_00A0;
  localparam logic [31:0] EXP_W2RD  = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_W1    = 32'h0000_BEEF;
  localparam logic [31:0] EXP_W2REG = 32'h0000_00AB;
  localparam logic [31:0] EXP_W2RD  = 32'h0000_000B;
`endif

  logic           clk;
  logic           reset_n;
  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [1:0]     req_addr;
  logic [DW-1:0]  req_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_error;
  logic [NW*DW-1:0] regs_out;
`ifdef COMPONENT_REGS_W1C_EN
  logic [NW*DW-1:0] hw_set;
`endif

  int checks   = 0;
  int failures = 0;

  logic [NW*DW-1:0] exp_regs;
  logic [31:0]      rd;
  logic             err;

  component_register_bank #(
    .NUM_WORDS   (NW),
    .DATA_WIDTH  (DW),
    .READ_MASK   (RM),
    .WRITE_MASK  (WM),
    .RESET_VALUE (RV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .regs_out  (regs_out)
`ifdef COMPONENT_REGS_W1C_EN
    ,
    .hw_set    (hw_set)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NW*DW-1:0] obs, input logic [NW*DW-1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One complete access with rsp_ready high: accept edge, then release edge.
  task automatic access(input logic wr, input logic [1:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic rerr);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    check("rsp_valid_latency", {95'd0, rsp_valid}, 96'd1);
    check("req_ready_in_resp", {95'd0, req_ready}, 96'd0);
    rdata     = rsp_rdata;
    rerr      = rsp_error;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rsp_valid_released", {95'd0, rsp_valid}, 96'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 2'd0;
    req_wdata = '0;
    rsp_ready = 1'b1;
`ifdef COMPONENT_REGS_W1C_EN
    hw_set    = '0;
`endif
    exp_regs  = RV;

    repeat (2) @(negedge clk);
    check("reset_rsp_valid", {95'd0, rsp_valid}, 96'd0);
    check("reset_rsp_rdata", {64'd0, rsp_rdata}, 96'd0);
    check("reset_rsp_error", {95'd0, rsp_error}, 96'd0);
    check("reset_regs_out", regs_out, RV);
    reset_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_reset", {95'd0, req_ready}, 96'd1);

    access(1'b0, 2'd0, 32'h0, rd, err);
    check("read0_data", {64'd0, rd}, {64'd0, 32'h1234_5678});
    check("read0_error", {95'd0, err}, 96'd0);

    access(1'b1, 2'd1, 32'hDEAD_BEEF, rd, err);
    check("write1_rdata_zero", {64'd0, rd}, 96'd0);
    check("write1_error", {95'd0, err}, 96'd0);
    exp_regs[63:32] = EXP_W1;
    check("write1_regs_out", regs_out, exp_regs);
    access(1'b0, 2'd1, 32'h0, rd, err);
    check("read1_masked_write", {64'd0, rd}, {64'd0, EXP_W1});

    access(1'b1, 2'd0, 32'hFFFF_FFFF, rd, err);
    access(1'b0, 2'd0, 32'h0, rd, err);
    check("read0_const_after_write", {64'd0, rd}, {64'd0, 32'h1234_5678});

    access(1'b1, 2'd2, 32'h0000_00AB, rd, err);
    exp_regs[95:64] = EXP_W2REG;
    check("write2_regs_out", regs_out, exp_regs);
    access(1'b0, 2'd2, 32'h0, rd, err);
    check("read2_write_only_bits", {64'd0, rd}, {64'd0, EXP_W2RD});

    access(1'b1, 2'd3, 32'hFFFF_FFFF, rd, err);
    check("oob_write_error", {95'd0, err}, 96'd1);
    access(1'b0, 2'd3, 32'h0, rd, err);
    check("oob_read_error", {95'd0, err}, 96'd1);
    check("oob_read_rdata", {64'd0, rd}, 96'd0);
    check("oob_regs_unchanged", regs_out, exp_regs);

    // Response stall: held for 5 cycles, stray request must be ignored.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 2'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i == 2);
      req_write = 1'b1;
      req_addr  = 2'd1;
      req_wdata = 32'h0000_1111;
      #1;
      check("stall_rsp_valid", {95'd0, rsp_valid}, 96'd1);
      check("stall_rsp_rdata", {64'd0, rsp_rdata}, {64'd0, EXP_W1});
      check("stall_req_ready", {95'd0, req_ready}, 96'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_released", {95'd0, rsp_valid}, 96'd0);
    check("stall_write_ignored", regs_out, exp_regs);

`ifdef COMPONENT_REGS_W1C_EN
    @(negedge clk);
    hw_set[67] = 1'b1;
    @(negedge clk);
    hw_set = '0;
    access(1'b0, 2'd2, 32'h0, rd, err);
    check("w1c_set_read", {64'd0, rd}, {64'd0, 32'h8});

    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 2'd2;
    req_wdata  = 32'h8;
    hw_set[67] = 1'b1;
    @(posedge clk);
    #1;
    hw_set    = '0;
    req_valid = 1'b0;
    exp_regs[95:64] = 32'h8;
    check("w1c_set_wins_regs", regs_out, exp_regs);
    @(posedge clk);
    access(1'b0, 2'd2, 32'h0, rd, err);
    check("w1c_set_wins_read", {64'd0, rd}, {64'd0, 32'h8});

    access(1'b1, 2'd2, 32'h8, rd, err);
    access(1'b0, 2'd2, 32'h0, rd, err);
    check("w1c_clear_read", {64'd0, rd}, 96'd0);
`endif

    // Reset while a response is pending.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 2'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("pre_reset_rsp_valid", {95'd0, rsp_valid}, 96'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_rsp_valid", {95'd0, rsp_valid}, 96'd0);
    check("midreset_regs_out", regs_out, RV);
    @(negedge clk);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    access(1'b0, 2'd1, 32'h0, rd, err);
    check("read1_after_reset", {64'd0, rd}, 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/component_register_bank.md
Name: component_register_bank

Overview:
- Parametrised, bus-accessible bank of NUM_WORDS control/status registers, DATA_WIDTH bits each.
- Per-bit read and write masks are supplied as flattened parameters, normally packed-struct localparams from the register package.
- Single-outstanding request/response handshake; sits between the component's host-bus adapter and its datapath.
- Register contents are exported flattened to the datapath.

Parameters:
- NUM_WORDS, 4, number of DATA_WIDTH-bit registers (>=1).
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, (NUM_WORDS>1 ? $clog2(NUM_WORDS) : 1), word-address width; derived, not overridden.
- READ_MASK, '1 (NUM_WORDS*DATA_WIDTH bits), 1 = bit readable; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- WRITE_MASK, '0 (NUM_WORDS*DATA_WIDTH bits), 1 = bit host-writable.
- RESET_VALUE, '0 (NUM_WORDS*DATA_WIDTH bits), reset contents; constant fields (e.g. version word) live here with WRITE_MASK = 0.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  bank can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  DATA_WIDTH  read data, masked.
- rsp_error  output  1  address out of range.
- regs_out  output  NUM_WORDS*DATA_WIDTH  current register contents, unmasked.
- hw_set  input  NUM_WORDS*DATA_WIDTH  sticky-status set pulses; present only when COMPONENT_REGS_W1C_EN is defined.

Behaviour:
- Reset (async assert, sync deassert in the parent):
  - regs <= RESET_VALUE.
  - State IDLE; rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
  - req_ready = 1 once reset is released.
- State machine:
  - IDLE: req_ready = 1. On req_valid & req_ready, capture the request, perform the access, go to RESP.
  - RESP: req_ready = 0, rsp_valid = 1, response outputs held stable. On rsp_ready, go to IDLE.
  - No pipelining of back-to-back requests: maximum throughput is one access per 2 cycles when rsp_ready is tied high.
- Latency: request accepted at edge N; rsp_valid high from N+1.
- Read, addr < NUM_WORDS: rsp_rdata = word[addr] & READ_MASK word[addr], sampled at the accept edge; rsp_error = 0.
- Write, addr < NUM_WORDS:
  - word <= (word & ~WM) | (wdata & WM), where WM is the WRITE_MASK word; applied at the accept edge.
  - Response has rsp_rdata = 0, rsp_error = 0.
- addr >= NUM_WORDS, only reachable when NUM_WORDS is not a power of two:
  - No state change; rsp_rdata = 0, rsp_error = 1.
- Bits with WRITE_MASK = 0 are never changed by host writes and keep RESET_VALUE, except for sticky-status updates.
- A read of a write-only bit (READ_MASK = 0) returns 0.
- regs_out reflects a write from the cycle after the accept edge.
- Reset mid-transaction: the response is dropped, rsp_valid goes 0 immediately, and the registers return to RESET_VALUE.
- req_* inputs are ignored while in RESP.

Optional Feature:
- Macro COMPONENT_REGS_W1C_EN.
- Defined:
  - hw_set port exists. Every bit with WRITE_MASK = 1 and READ_MASK = 1 behaves as sticky write-1-to-clear:
    - hw_set bit = 1 sets the register bit.
    - A host write with wdata bit = 1 clears it; wdata bit = 0 leaves it unchanged.
  - Simultaneous set and clear on the same cycle: set wins, bit = 1.
  - Bits with WRITE_MASK = 0 also accept hw_set (read-only status).
- Undefined:
  - No hw_set port.
  - All writable bits use the plain masked-write rule above.

Decomposition:
- Package component_regs_pkg holds:
  - version_register_t and component_registers_t packed structs.
  - Derived register_bits_t.
  - Read, write and reset localparams built with '{default:...} and cast to register_bits_t.
  - bank_state_t enum {IDLE, RESP}.
- One sub-module, component_reg_word: a single DATA_WIDTH register with its mask and reset-value slices, masked-write and optional W1C logic. The bank generates NUM_WORDS instances plus the FSM and read mux.

Test Plan:
- Reset with RESET_VALUE word0 = 32'h1234_5678 and READ_MASK '1; read addr 0 -> rsp_valid at the cycle after accept, rsp_rdata = 32'h1234_5678, rsp_error = 0.
- WRITE_MASK word1 = 32'h0000_FFFF; write 32'hDEAD_BEEF to addr 1, then read addr 1 -> 32'h0000_BEEF (upper half stays 0).
- NUM_WORDS = 3; read addr 3 -> rsp_error = 1, rsp_rdata = 0; regs_out unchanged.
- Hold rsp_ready = 0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable throughout, req_ready = 0; a req_valid pulse in that window is not accepted.
- Assert reset_n = 0 while in RESP -> rsp_valid = 0 in the same cycle, regs_out = RESET_VALUE.
- With COMPONENT_REGS_W1C_EN:
  - hw_set word2 bit 3 pulse; read addr 2 -> 32'h8.
  - Write 32'h8 to addr 2 with a simultaneous hw_set on bit 3 -> still 32'h8.
  - Next write of 32'h8 -> 32'h0.
